// File: rtl/uart_bus_arbiter.sv
// Two-requester round-robin arbiter in front of the UART register port.
// One transaction per IDLE -> ACCESS -> RESP cycle, with an optional bounded burst lock.
module uart_bus_arbiter #(
  parameter int unsigned MAX_LOCK = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic        req0_we,
  input  logic        req0_lock,
  input  logic [3:0]  req0_addr,
  input  logic [31:0] req0_wdata,
  output logic        req0_ack,
  output logic [31:0] req0_rdata,
  input  logic        req1_valid,
  input  logic        req1_we,
  input  logic        req1_lock,
  input  logic [3:0]  req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        req1_ack,
  output logic [31:0] req1_rdata,
  output logic        uart_sel,
  output logic        uart_wr_enable,
  output logic [3:0]  uart_addr,
  output logic [31:0] wdata_mem,
  input  logic [31:0] uart_data,
  output logic        grant_id,
  output logic        busy
);

  localparam int unsigned CW = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] MAX_LOCK_C = CW'(MAX_LOCK);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic           last_grant_q, last_grant_d;
  logic           grant_id_q, grant_id_d;
  logic           lock_active_q, lock_active_d;
  logic           lock_owner_q, lock_owner_d;
  logic [CW-1:0]  lock_count_q, lock_count_d;
  logic [3:0]     addr_q, addr_d;
  logic           we_q, we_d;
  logic [31:0]    wdata_q, wdata_d;
  logic [31:0]    rdata_q, rdata_d;

  logic           owner_valid;
  logic           win_valid;
  logic           winner;
  logic           win_lock;
  logic [CW-1:0]  lock_inc;

  assign owner_valid = lock_owner_q ? req1_valid : req0_valid;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    grant_id_d    = grant_id_q;
    lock_active_d = lock_active_q;
    lock_owner_d  = lock_owner_q;
    lock_count_d  = lock_count_q;
    addr_d        = addr_q;
    we_d          = we_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    win_valid     = 1'b0;
    winner        = 1'b0;
    win_lock      = 1'b0;
    lock_inc      = '0;

    unique case (state_q)
      IDLE: begin
        // An owner that went idle forfeits the lock; arbitration still runs this cycle.
        if (lock_active_q && !owner_valid) begin
          lock_active_d = 1'b0;
          lock_count_d  = '0;
        end

        if (lock_active_q && owner_valid) begin
          win_valid = 1'b1;
          winner    = lock_owner_q;
        end else if (req0_valid && req1_valid) begin
          win_valid = 1'b1;
          winner    = ~last_grant_q;
        end else if (req0_valid) begin
          win_valid = 1'b1;
          winner    = 1'b0;
        end else if (req1_valid) begin
          win_valid = 1'b1;
          winner    = 1'b1;
        end

        if (win_valid) begin
          addr_d       = winner ? req1_addr  : req0_addr;
          we_d         = winner ? req1_we    : req0_we;
          wdata_d      = winner ? req1_wdata : req0_wdata;
          win_lock     = winner ? req1_lock  : req0_lock;
          last_grant_d = winner;
          grant_id_d   = winner;
          state_d      = ACCESS;

          if (win_lock) begin
            lock_inc = lock_count_d + CW'(1);
            if (lock_inc == MAX_LOCK_C) begin
              lock_active_d = 1'b0;
              lock_count_d  = '0;
            end else begin
              lock_active_d = 1'b1;
              lock_owner_d  = winner;
              lock_count_d  = lock_inc;
            end
          end else begin
            lock_active_d = 1'b0;
            lock_count_d  = '0;
          end
        end
      end

      ACCESS: begin
        rdata_d = we_q ? '0 : uart_data;
        state_d = RESP;
      end

      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      grant_id_q    <= 1'b0;
      lock_active_q <= 1'b0;
      lock_owner_q  <= 1'b0;
      lock_count_q  <= '0;
      addr_q        <= '0;
      we_q          <= 1'b0;
      wdata_q       <= '0;
      rdata_q       <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      grant_id_q    <= grant_id_d;
      lock_active_q <= lock_active_d;
      lock_owner_q  <= lock_owner_d;
      lock_count_q  <= lock_count_d;
      addr_q        <= addr_d;
      we_q          <= we_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
    end
  end

  // Downstream strobes come straight from state so an async reset drops them at once.
  assign uart_sel       = (state_q == ACCESS);
  assign uart_wr_enable = uart_sel & we_q;
  assign uart_addr      = uart_sel ? addr_q  : '0;
  assign wdata_mem      = uart_sel ? wdata_q : '0;

  assign req0_ack   = (state_q == RESP) && !grant_id_q;
  assign req1_ack   = (state_q == RESP) &&  grant_id_q;
  assign req0_rdata = req0_ack ? rdata_q : '0;
  assign req1_rdata = req1_ack ? rdata_q : '0;

  assign grant_id = grant_id_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Directed bench for uart_bus_arbiter (MAX_LOCK=4): handshake latency, round-robin,
// lock bound, async-reset abort and field stability after acceptance.
module tb_uart_bus_arbiter;

  logic        clock;
  logic        reset;
  logic        req0_valid, req0_we, req0_lock;
  logic [3:0]  req0_addr;
  logic [31:0] req0_wdata;
  logic        req0_ack;
  logic [31:0] req0_rdata;
  logic        req1_valid, req1_we, req1_lock;
  logic [3:0]  req1_addr;
  logic [31:0] req1_wdata;
  logic        req1_ack;
  logic [31:0] req1_rdata;
  logic        uart_sel, uart_wr_enable;
  logic [3:0]  uart_addr;
  logic [31:0] wdata_mem;
  logic [31:0] uart_data;
  logic        grant_id, busy;

  int vectors     = 0;
  int miscompares = 0;

  uart_bus_arbiter #(.MAX_LOCK(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .req0_valid     (req0_valid),
    .req0_we        (req0_we),
    .req0_lock      (req0_lock),
    .req0_addr      (req0_addr),
    .req0_wdata     (req0_wdata),
    .req0_ack       (req0_ack),
    .req0_rdata     (req0_rdata),
    .req1_valid     (req1_valid),
    .req1_we        (req1_we),
    .req1_lock      (req1_lock),
    .req1_addr      (req1_addr),
    .req1_wdata     (req1_wdata),
    .req1_ack       (req1_ack),
    .req1_rdata     (req1_rdata),
    .uart_sel       (uart_sel),
    .uart_wr_enable (uart_wr_enable),
    .uart_addr      (uart_addr),
    .wdata_mem      (wdata_mem),
    .uart_data      (uart_data),
    .grant_id       (grant_id),
    .busy           (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // UART read-data model, combinational from the register address.
  always_comb begin
    uart_data = 32'hDEAD_0000 | {28'h0, uart_addr};
    case (uart_addr)
      4'h4:    uart_data = 32'h0000_00A5;
      4'h8:    uart_data = 32'h0000_005A;
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    req0_valid = 1'b0; req0_we = 1'b0; req0_lock = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_lock = 1'b0; req1_addr = '0; req1_wdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Expects the accept edge next: one ACCESS cycle, then one RESP cycle.
  task automatic run_txn(input string tag, input logic gid, input logic [3:0] addr,
                         input logic we, input logic [31:0] wdata, input logic [31:0] rdata);
    tick();
    check({tag, " acc sel"},   uart_sel, 1'b1);
    check({tag, " acc gid"},   grant_id, gid);
    check({tag, " acc addr"},  uart_addr, addr);
    check({tag, " acc we"},    uart_wr_enable, we);
    check({tag, " acc wdata"}, wdata_mem, wdata);
    check({tag, " acc acks"},  {req1_ack, req0_ack}, 2'b00);
    tick();
    check({tag, " rsp sel"},   uart_sel, 1'b0);
    check({tag, " rsp ack0"},  req0_ack, !gid);
    check({tag, " rsp ack1"},  req1_ack, gid);
    check({tag, " rsp rd0"},   req0_rdata, gid ? 32'h0 : rdata);
    check({tag, " rsp rd1"},   req1_rdata, gid ? rdata : 32'h0);
  endtask

  task automatic idle_step(input string tag);
    tick();
    check({tag, " idle busy"}, busy, 1'b0);
    check({tag, " idle acks"}, {req1_ack, req0_ack}, 2'b00);
  endtask

  initial begin
    logic exp4a [5];
    exp4a = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    reset = 1'b0;
    clear_inputs();
    #1;
    check("reset sel",   uart_sel, 1'b0);
    check("reset busy",  busy, 1'b0);
    check("reset gid",   grant_id, 1'b0);
    check("reset acks",  {req1_ack, req0_ack}, 2'b00);
    check("reset rdata", req0_rdata | req1_rdata, 32'h0);
    tick();
    tick();
    reset = 1'b1;

    // 1: single write from requester 0.
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 4'h0; req0_wdata = 32'h41;
    run_txn("t1", 1'b0, 4'h0, 1'b1, 32'h41, 32'h0);
    req0_valid = 1'b0;
    idle_step("t1");

    // 2: simultaneous reads after reset; req0 wins the first tie.
    do_reset();
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 4'h4;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 4'h8;
    run_txn("t2a", 1'b0, 4'h4, 1'b0, 32'h0, 32'hA5);
    req0_valid = 1'b0;
    idle_step("t2");
    run_txn("t2b", 1'b1, 4'h8, 1'b0, 32'h0, 32'h5A);
    req1_valid = 1'b0;
    idle_step("t2b");

    // 3: both continuously valid without lock alternate 0,1,0,1,0,1.
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 4'h1; req0_wdata = 32'h1111_0000;
    req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 4'h2; req1_wdata = 32'h2222_0000;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) run_txn("t3", 1'b0, 4'h1, 1'b1, 32'h1111_0000, 32'h0);
      else            run_txn("t3", 1'b1, 4'h2, 1'b1, 32'h2222_0000, 32'h0);
      idle_step("t3");
    end
    clear_inputs();

    // 4a: req0 locked continuously hits the bound of 4, then req1 gets in.
    do_reset();
    req0_valid = 1'b1; req0_we = 1'b1; req0_lock = 1'b1; req0_addr = 4'h5; req0_wdata = 32'h55;
    req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 4'h6; req1_wdata = 32'h66;
    for (int i = 0; i < 5; i++) begin
      if (exp4a[i]) run_txn("t4a", 1'b1, 4'h6, 1'b1, 32'h66, 32'h0);
      else          run_txn("t4a", 1'b0, 4'h5, 1'b1, 32'h55, 32'h0);
      idle_step("t4a");
    end

    // 4b: req0 drops lock on its second transaction; req1 is granted third.
    do_reset();
    req0_valid = 1'b1; req0_we = 1'b1; req0_lock = 1'b1; req0_addr = 4'h5; req0_wdata = 32'h55;
    req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 4'h6; req1_wdata = 32'h66;
    run_txn("t4b1", 1'b0, 4'h5, 1'b1, 32'h55, 32'h0);
    req0_lock = 1'b0;
    idle_step("t4b1");
    run_txn("t4b2", 1'b0, 4'h5, 1'b1, 32'h55, 32'h0);
    idle_step("t4b2");
    run_txn("t4b3", 1'b1, 4'h6, 1'b1, 32'h66, 32'h0);
    clear_inputs();
    idle_step("t4b3");

    // 5: async reset in the middle of a req1 ACCESS aborts it.
    do_reset();
    req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 4'h7; req1_wdata = 32'h77;
    tick();
    check("t5 acc sel", uart_sel, 1'b1);
    check("t5 acc gid", grant_id, 1'b1);
    #3;
    reset = 1'b0;
    #1;
    check("t5 rst sel",  uart_sel, 1'b0);
    check("t5 rst busy", busy, 1'b0);
    check("t5 rst ack1", req1_ack, 1'b0);
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 4'h1; req0_wdata = 32'h11;
    tick();
    check("t5 hold ack1", req1_ack, 1'b0);
    reset = 1'b1;
    run_txn("t5a", 1'b0, 4'h1, 1'b1, 32'h11, 32'h0);
    req0_valid = 1'b0;
    idle_step("t5a");
    run_txn("t5b", 1'b1, 4'h7, 1'b1, 32'h77, 32'h0);
    clear_inputs();
    idle_step("t5b");

    // 6: req1 changes fields after acceptance; UART still sees latched values.
    req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 4'h3; req1_wdata = 32'hCAFE_0003;
    tick();
    req1_addr = 4'h9; req1_wdata = 32'hBEEF_0009;
    #1;
    check("t6 acc sel",   uart_sel, 1'b1);
    check("t6 acc addr",  uart_addr, 4'h3);
    check("t6 acc wdata", wdata_mem, 32'hCAFE_0003);
    check("t6 acc we",    uart_wr_enable, 1'b1);
    tick();
    check("t6 rsp ack1",  req1_ack, 1'b1);
    check("t6 rsp ack0",  req0_ack, 1'b0);
    check("t6 rsp sel",   uart_sel, 1'b0);
    clear_inputs();
    idle_step("t6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
